writeback_stage: RTL and testbench

Final pipeline stage directly upstream of the register file. It accepts results from the ALU path and the load path over valid/ready handshakes and arbitrates between them. Load data is byte/halfword-aligned and sign/zero-extended. It drives a registered single write port (write_enable, rd, reg_data_in) into the register file, plus a bypass copy for forwarding.

---
 rtl/bark_pkg.sv | 23 ++
 rtl/load_extend.sv | 37 +++
 rtl/writeback_stage.sv | 117 +++++++++++
 tb/tb_writeback_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bark_pkg.sv
// Shared definitions for the writeback stage.
//   DATA_WIDTH / ADDR_WIDTH : default datapath and register-index widths.
//   load_funct3_t           : RV32 load encodings understood by the load path.
//   wb_req_t                : one register-file write request {rd, data}.
package bark_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner / extender for RV32 loads.
//   word    : raw aligned 32-bit memory word.
//   funct3  : load type (LB, LH, LW, LBU, LHU; other codes are reserved).
//   offset  : address bits [1:0]; selects the byte, offset[1] selects the halfword.
//   data    : extended result (0 for a reserved funct3).
//   illegal : high when funct3 is a reserved code.
module load_extend
  import bark_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword loads ignore offset[0]; misaligned halfwords never reach this stage.
  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'h0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'h0, half_sel};
      LW:      data = word;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage in front of the register file.
// Arbitrates between the ALU and load result paths, extends load data, and
// drives a registered write port plus a bypass copy for forwarding.
//
// Handshake: a source transfers on a cycle where its valid and ready are both
// high at the rising clock edge. Ready is combinational from the valids and the
// starvation counter, is never high without the matching valid, at most one
// ready is high per cycle, and both are low while reset is asserted.
//
// Ports:
//   clock, reset                         : clock, async active-low reset.
//   alu_valid/alu_ready/alu_rd/alu_data  : ALU result input.
//   load_valid/load_ready/load_rd/
//   load_word/load_funct3/load_byte_offset : load result input.
//   write_enable/rd/reg_data_in          : register-file write port.
//   wb_valid/wb_rd/wb_data               : bypass copy of the output register.
//   wb_illegal                           : accepted load had a reserved funct3.
module writeback_stage
  import bark_pkg::*;
#(
  parameter int DATA_WIDTH   = bark_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = bark_pkg::ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_rd,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic [2:0]            load_funct3,
  input  logic [1:0]            load_byte_offset,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] reg_data_in,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_illegal
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             alu_priority;
  logic             load_grant;
  logic             alu_grant;
  logic [31:0]      load_data;
  logic             load_illegal;
  wb_req_t          next_req;
  wb_req_t          out_q;

  load_extend u_load_extend (
    .word    (load_word),
    .funct3  (load_funct3),
    .offset  (load_byte_offset),
    .data    (load_data),
    .illegal (load_illegal)
  );

  // Loads win contention until the ALU has lost STARVE_LIMIT cycles in a row.
  assign alu_priority = (starve_cnt == STARVE_MAX);
  assign load_grant   = reset && load_valid && !(alu_valid && alu_priority);
  assign alu_grant    = reset && alu_valid && !load_grant;

  assign alu_ready  = alu_grant;
  assign load_ready = load_grant;

  always_comb begin
    next_req.rd   = alu_rd;
    next_req.data = alu_data;
    if (load_grant) begin
      next_req.rd   = load_rd;
      next_req.data = load_data;
    end
  end

  // Counts consecutive cycles the ALU waited; any gap in alu_valid restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Output register: valid/strobe reload every cycle, index and data hold when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q        <= '0;
      wb_valid     <= 1'b0;
      write_enable <= 1'b0;
      wb_illegal   <= 1'b0;
    end else begin
      wb_valid     <= load_grant || alu_grant;
      // x0 results are visible on the bypass but never written.
      write_enable <= (load_grant || alu_grant) && (next_req.rd != '0);
      wb_illegal   <= load_grant && load_illegal;
      if (load_grant || alu_grant) begin
        out_q <= next_req;
      end
    end
  end

  assign rd          = out_q.rd;
  assign reg_data_in = out_q.data;
  assign wb_rd       = out_q.rd;
  assign wb_data     = out_q.data;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;
  localparam int W     = AW + DW;

  logic          clock;
  logic          reset;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_rd;
  logic [DW-1:0] load_word;
  logic [2:0]    load_funct3;
  logic [1:0]    load_byte_offset;
  logic          write_enable;
  logic [AW-1:0] rd;
  logic [DW-1:0] reg_data_in;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_illegal;

  writeback_stage #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_rd          (load_rd),
    .load_word        (load_word),
    .load_funct3      (load_funct3),
    .load_byte_offset (load_byte_offset),
    .write_enable     (write_enable),
    .rd               (rd),
    .reg_data_in      (reg_data_in),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .wb_illegal       (wb_illegal)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- check bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Load extension from arithmetic on the selected byte/halfword value.
  function automatic logic [DW-1:0] extend_model(input logic [DW-1:0] word,
                                                 input logic [2:0] f3,
                                                 input int o,
                                                 output bit ill);
    int unsigned b;
    int unsigned h;
    b   = (word >> (8 * o)) & 32'hFF;
    h   = (word >> (16 * (o / 2))) & 32'hFFFF;
    ill = 1'b0;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: begin
        ill = 1'b1;
        return 0;
      end
    endcase
  endfunction

  int            m_starve;   // consecutive cycles the ALU waited
  logic          m_valid = 1'b0;
  logic          m_we    = 1'b0;
  logic          m_ill   = 1'b0;
  logic [AW-1:0] m_rd    = '0;
  logic [DW-1:0] m_data  = '0;
  logic [W-1:0]  exp_q[$];   // scoreboard of expected register-file writes

  bit            take_load;
  bit            take_alu;
  bit            ld_ill;
  logic [DW-1:0] ld_val;

  initial m_starve = 0;

  task automatic model_clear();
    m_starve = 0;
    m_valid  = 1'b0;
    m_we     = 1'b0;
    m_ill    = 1'b0;
    m_rd     = '0;
    m_data   = '0;
    exp_q.delete();
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clock) begin
    if (!reset) begin
      model_clear();
    end else begin
      take_load = load_valid && !(alu_valid && m_starve == LIMIT);
      take_alu  = alu_valid && !take_load;
      ld_val    = extend_model(load_word, load_funct3, int'(load_byte_offset), ld_ill);
      m_valid   = take_load || take_alu;
      m_ill     = take_load && ld_ill;
      if (take_load) begin
        m_rd   = load_rd;
        m_data = ld_val;
      end else if (take_alu) begin
        m_rd   = alu_rd;
        m_data = alu_data;
      end
      m_we = m_valid && (m_rd != 0);
      if (m_we) exp_q.push_back({m_rd, m_data});
      if (alu_valid && !take_alu) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
    end
  end

  // ---------------- compare process ----------------
  logic         e_load_rdy;
  logic         e_alu_rdy;
  logic [W-1:0] sb_item;

  always @(negedge clock) begin
    e_load_rdy = reset && load_valid && !(alu_valid && m_starve == LIMIT);
    e_alu_rdy  = reset && alu_valid && !e_load_rdy;
    chk("alu_ready", alu_ready, e_alu_rdy);
    chk("load_ready", load_ready, e_load_rdy);
    chk("wb_valid", wb_valid, m_valid);
    chk("write_enable", write_enable, m_we);
    chk("wb_illegal", wb_illegal, m_ill);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_data", wb_data, m_data);
    chk("rd_eq_wb_rd", rd, m_rd);
    chk("reg_data_in", reg_data_in, m_data);
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 1, 0);
      end else begin
        sb_item = exp_q.pop_front();
        chk("sb_write", {rd, reg_data_in}, sb_item);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid  = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
    alu_valid = 1'b1;
    alu_rd    = r;
    alu_data  = d;
  endtask

  task automatic drive_load(input logic [AW-1:0] r, input logic [DW-1:0] w,
                            input logic [2:0] f3, input logic [1:0] o);
    load_valid       = 1'b1;
    load_rd          = r;
    load_word        = w;
    load_funct3      = f3;
    load_byte_offset = o;
  endtask

  // ---------------- directed stimulus ----------------
  logic [2:0]    v_f3[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]    v_off[5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [DW-1:0] v_exp[5] = '{32'hFFFFFF81, 32'h00000080, 32'hFFFF80F0,
                              32'h00007F81, 32'h80F07F81};
  bit            dummy_ill;

  initial begin
    reset            = 1'b0;
    alu_valid        = 1'b0;
    alu_rd           = '0;
    alu_data         = '0;
    load_valid       = 1'b0;
    load_rd          = '0;
    load_word        = '0;
    load_funct3      = '0;
    load_byte_offset = '0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    // Idle after reset release: everything at zero.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_alu_ready", alu_ready, 0);
      chk("idle_load_ready", load_ready, 0);
      chk("idle_we", write_enable, 0);
      chk("idle_wb_valid", wb_valid, 0);
      chk("idle_data", reg_data_in, 0);
    end

    // First ALU result: ready same cycle, written one cycle later.
    drive_alu(5'd3, 32'hDEADBEEF);
    #1 chk("alu_ready_same_cycle", alu_ready, 1);
    cyc();
    idle();
    chk("alu_we", write_enable, 1);
    chk("alu_rd", rd, 3);
    chk("alu_data", reg_data_in, 32'hDEADBEEF);

    // Load extension vectors on 0x80F07F81, back to back.
    for (int i = 0; i < 5; i++) begin
      chk("model_pin_ext", extend_model(32'h80F07F81, v_f3[i], int'(v_off[i]), dummy_ill), v_exp[i]);
      drive_load(AW'(10 + i), 32'h80F07F81, v_f3[i], v_off[i]);
      cyc();
      chk("ext_data", reg_data_in, v_exp[i]);
      chk("ext_rd", rd, 10 + i);
    end
    idle();
    cyc();

    // Contention: four loads, then the starved ALU, repeating.
    for (int i = 0; i < 10; i++) begin
      drive_alu(5'd20, 32'hA0000000 + i);
      drive_load(5'd21, 32'h00000100 + i, 3'b010, 2'd0);
      #1;
      chk("starve_alu_ready", alu_ready, (i % 5) == 4);
      chk("starve_load_ready", load_ready, (i % 5) != 4);
      cyc();
      chk("starve_rd", rd, ((i % 5) == 4) ? 20 : 21);
    end
    idle();
    cyc();

    // x0 result: visible on bypass, never written.
    drive_alu(5'd0, 32'h00001234);
    cyc();
    idle();
    chk("x0_wb_valid", wb_valid, 1);
    chk("x0_wb_data", wb_data, 32'h1234);
    chk("x0_we", write_enable, 0);

    // Reserved funct3: written as zero, flagged for one cycle.
    drive_load(5'd7, 32'hFFFFFFFF, 3'b011, 2'd0);
    cyc();
    idle();
    chk("ill_we", write_enable, 1);
    chk("ill_rd", rd, 7);
    chk("ill_data", reg_data_in, 0);
    chk("ill_flag", wb_illegal, 1);
    cyc();
    chk("ill_flag_clear", wb_illegal, 0);

    // Asynchronous reset while a result sits in the output register.
    drive_alu(5'd9, 32'h00000055);
    cyc();
    idle();
    chk("pre_reset_wb_valid", wb_valid, 1);
    #2 reset = 1'b0;
    drive_alu(5'd12, 32'h00000077);
    #1;
    chk("async_we", write_enable, 0);
    chk("async_wb_valid", wb_valid, 0);
    chk("async_rd", rd, 0);
    chk("async_alu_ready", alu_ready, 0);
    @(posedge clock);
    #2 reset = 1'b1;
    idle();
    cyc();
    chk("post_reset_we", write_enable, 0);
    chk("post_reset_wb_valid", wb_valid, 0);

    repeat (2) cyc();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
